// File: rtl/spm_seq.sv
// Sequencer for the spm serial-parallel multiplier: accepts a signed operand pair,
// streams the multiplier LSB-first (sign-extended) and collects the 2*SIZE-bit product.
module spm_seq #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_a,
    input  logic [SIZE-1:0]     in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_p,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    output logic                spm_rst,
    input  logic                spm_p
);

    localparam int CW = $clog2(2*SIZE+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*SIZE);
    localparam logic [CW-1:0] CNT_YEND = CW'(2*SIZE-1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [SIZE-1:0]     b_sh;
    logic [2*SIZE-1:0]   prod;

    // The multiplier is arithmetic-shifted right, so its LSB is the next serial bit
    // and the sign bit repeats automatically once the original bits are used up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            b_sh      <= '0;
            prod      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            spm_x     <= '0;
            spm_y     <= 1'b0;
            spm_rst   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        spm_x    <= in_a;
                        b_sh     <= in_b;
                        in_ready <= 1'b0;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt     <= '0;
                    prod    <= '0;
                    spm_rst <= 1'b0;
                    spm_y   <= b_sh[0];
                    b_sh    <= {b_sh[SIZE-1], b_sh[SIZE-1:1]};
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        prod <= {spm_p, prod[2*SIZE-1:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        out_p     <= {spm_p, prod[2*SIZE-1:1]};
                        out_valid <= 1'b1;
                        spm_rst   <= 1'b1;
                        spm_y     <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        spm_y <= (cnt == CNT_YEND) ? 1'b0 : b_sh[0];
                        b_sh  <= {b_sh[SIZE-1], b_sh[SIZE-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq: a behavioural serial multiplier stands in for the spm array,
// and a scoreboard compares every returned product against plain signed arithmetic.
module tb_spm_seq;

    localparam int SIZE = 32;
    localparam int LAT  = 2*SIZE+2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_p;
    logic [31:0]   spm_x;
    logic          spm_y;
    logic          spm_rst;
    logic          spm_p;

    typedef struct {
        logic [31:0] a;
        logic [63:0] p;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    logic [63:0] mdl_y;
    int          mdl_k;

    spm_seq #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .spm_x(spm_x), .spm_y(spm_y), .spm_rst(spm_rst), .spm_p(spm_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Product bit k of x times the serial multiplier seen so far; bits above k cannot affect it.
    function automatic logic serialBit(input logic [31:0] x, input logic [63:0] y, input int k);
        logic [63:0] p;
        logic [63:0] t;
        p = {{32{x[31]}}, x} * y;
        t = p >> k;
        return t[0];
    endfunction

    // Stand-in spm array: one cycle from multiplier bit k to product bit k.
    always @(posedge clk) begin
        if (spm_rst) begin
            mdl_k <= 0;
            mdl_y <= '0;
            spm_p <= 1'b0;
        end else begin
            mdl_y <= mdl_y | ({63'b0, spm_y} << mdl_k);
            mdl_k <= mdl_k + 1;
            spm_p <= serialBit(spm_x, mdl_y | ({63'b0, spm_y} << mdl_k), mdl_k);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        int n;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            sbq.push_back('{a, p, cyc + 1});
            @(negedge clk);
            in_valid = 1'b0;
            in_a = $urandom();
            in_b = $urandom();
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sbq.size()), 64'(0));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 9))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard monitor: checks spm_x stability while shifting and every presented product.
    initial begin
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ov = 1'b0;
            end else begin
                if (!spm_rst && sbq.size() != 0)
                    checkOutput("spm_x_hold", 64'(spm_x), 64'(sbq[0].a));
                if (out_valid) begin
                    checkOutput("sb_has_entry", 64'(sbq.size() != 0), 64'(1));
                    if (sbq.size() != 0) begin
                        if (!prev_ov)
                            checkOutput("latency", 64'(cyc - sbq[0].acc), 64'(LAT));
                        checkOutput("out_p", out_p, sbq[0].p);
                        checkOutput("in_ready_in_done", 64'(in_ready), 64'(0));
                        if (out_ready) void'(sbq.pop_front());
                    end
                end
                prev_ov = out_valid && !out_ready;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] da[5];
        logic [31:0] db[5];
        logic [63:0] dp[5];
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        da = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
        db = '{32'd5, 32'd1,         32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000};
        dp = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0006,
               64'h3FFF_FFFF_0000_0001, 64'h4000_0000_0000_0000};

        rst = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_p", out_p, 64'(0));
        checkOutput("rst_spm_x", 64'(spm_x), 64'(0));
        checkOutput("rst_spm_y", 64'(spm_y), 64'(0));
        checkOutput("rst_spm_rst", 64'(spm_rst), 64'(1));
        rst = 1'b1;

        $display("[TB] directed pairs");
        for (int i = 0; i < 5; i++) applyStimulus(da[i], db[i], dp[i]);
        waitDrain();

        $display("[TB] backpressure");
        rdy_mode = 2;
        applyStimulus(32'hFFFF_FFFC, 32'd25, 64'hFFFF_FFFF_FFFF_FF9C);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_valid_seen", 64'(out_valid), 64'(1));
        repeat (10) @(negedge clk);
        checkOutput("bp_valid_held", 64'(out_valid), 64'(1));
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("bp_idle_in_ready", 64'(in_ready), 64'(1));
        checkOutput("bp_idle_out_valid", 64'(out_valid), 64'(0));
        applyStimulus(32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1);
        waitDrain();

        $display("[TB] reset mid-shift");
        applyStimulus(32'd1234567, 32'd7654321, refMul(32'd1234567, 32'd7654321));
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        sbq.delete();
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst_spm_rst", 64'(spm_rst), 64'(1));
        checkOutput("mid_rst_spm_x", 64'(spm_x), 64'(0));
        checkOutput("mid_rst_out_p", out_p, 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(32'd12, 32'd12, 64'd144);
        waitDrain();

        $display("[TB] random pairs");
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(ra, rb, refMul(ra, rb));
        end
        rdy_mode = 0;
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
